ofifo_deskew: RTL and testbench

- Output-side buffer of the MAC array; the receiving end of the skewed row stream that the L0 input bank launches.
- Each array column writes its partial sums on its own per-column strobe, arriving diagonally skewed by one cycle per column.
- The block holds one FIFO per column and re-aligns the data into whole rows.
- A single read pops one aligned row across all columns into the psum/SFU path.

---
 rtl/ofifo_deskew_if.sv | 30 +++
 rtl/ofifo_deskew.sv | 91 +++++++++
 tb/tb_ofifo_deskew.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ofifo_deskew_if.sv
// Bundle of the column-write / row-read signals between the MAC array output and the psum path.
// Latency: none; wires only.
// Backpressure: o_ready/o_full travel back to the writer, o_valid to the reader.
interface ofifo_deskew_if #(
   parameter int col     = 8,
   parameter int psum_bw = 16
);
   logic [col*psum_bw-1:0] in;
   logic [col-1:0]         wr;
   logic                   rd;
   logic [col*psum_bw-1:0] out;
   logic                   o_valid;
   logic                   o_out_valid;
   logic                   o_full;
   logic                   o_ready;
   logic                   o_ovf;
   logic                   o_udf;

   // Array/reader side: drives column data, strobes and row pops.
   modport master (
      output in, wr, rd,
      input  out, o_valid, o_out_valid, o_full, o_ready, o_ovf, o_udf
   );

   // Buffer side.
   modport slave (
      input  in, wr, rd,
      output out, o_valid, o_out_valid, o_full, o_ready, o_ovf, o_udf
   );
endinterface

// File: rtl/ofifo_deskew.sv
// Per-column FIFOs that re-align diagonally skewed partial sums into whole rows.
// Latency: rd accepted at edge N puts the row on out after edge N; no write-to-read fall-through.
// Backpressure: writes to a full lane are dropped (sticky o_ovf); rd without o_valid is ignored (sticky o_udf).
module ofifo_deskew #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int depth   = 64,
   parameter int ptr_bw  = 7
) (
   input logic          clk,
   input logic          reset,
   ofifo_deskew_if.slave bus
);
   // Address width of one lane; the extra pointer bit is the wrap bit.
   localparam int aw = ptr_bw - 1;

   logic [col-1:0]         empty;
   logic [col-1:0]         full;
   logic [col-1:0]         wr_en;
   logic [col*psum_bw-1:0] out_flat;
   logic                   valid;
   logic                   rd_acc;
   logic                   out_valid_q;
   logic                   ovf_q;
   logic                   udf_q;

   // A row exists only when every lane has at least one entry.
   assign valid  = ~|empty;
   assign rd_acc = bus.rd & valid;

   for (genvar i = 0; i < col; i++) begin : g_lane
      logic [ptr_bw-1:0]  wptr;
      logic [ptr_bw-1:0]  rptr;
      logic [psum_bw-1:0] mem [depth];
      logic [psum_bw-1:0] lane_out;

      assign empty[i] = (wptr == rptr);
      assign full[i]  = (wptr[aw-1:0] == rptr[aw-1:0]) && (wptr[aw] != rptr[aw]);
      // Full is taken pre-edge, so a pop in the same cycle does not rescue a blocked write.
      assign wr_en[i] = bus.wr[i] & ~full[i];
      assign out_flat[psum_bw*i +: psum_bw] = lane_out;

      // Lane storage; contents are left alone by reset, only the pointers are cleared.
      always_ff @(posedge clk) begin
         if (wr_en[i]) begin
            mem[wptr[aw-1:0]] <= bus.in[psum_bw*i +: psum_bw];
         end
      end

      // Write/read pointers; reset wins over any write or pop in the same cycle.
      always_ff @(posedge clk) begin
         if (reset) begin
            wptr <= '0;
            rptr <= '0;
         end else begin
            if (wr_en[i]) wptr <= wptr + 1'b1;
            if (rd_acc)   rptr <= rptr + 1'b1;
         end
      end

      // Registered head of this lane; holds whenever no row is popped.
      always_ff @(posedge clk) begin
         if (reset) begin
            lane_out <= '0;
         end else if (rd_acc) begin
            lane_out <= mem[rptr[aw-1:0]];
         end
      end
   end

   // Row-valid pulse and sticky error flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
      end else begin
         out_valid_q <= rd_acc;
         ovf_q       <= ovf_q | (|(bus.wr & full));
         udf_q       <= udf_q | (bus.rd & ~valid);
      end
   end

   assign bus.out         = out_flat;
   assign bus.o_valid     = valid;
   assign bus.o_out_valid = out_valid_q;
   assign bus.o_full      = |full;
   assign bus.o_ready     = ~(|full);
   assign bus.o_ovf       = ovf_q;
   assign bus.o_udf       = udf_q;
endmodule

// File: tb/tb_ofifo_deskew.sv
// Directed plus random checks of ofifo_deskew against a queue-per-column reference.
// Latency: one cycle per step; outputs checked 1 time unit after each rising edge.
// Backpressure: the reference drops writes to full columns and ignores pops without a full row.
module tb_ofifo_deskew;
   localparam int COL   = 8;
   localparam int BW    = 16;
   localparam int DEPTH = 64;
   localparam int W     = COL*BW;

   logic clk = 1'b0;
   logic reset;

   ofifo_deskew_if #(.col(COL), .psum_bw(BW)) bif ();

   ofifo_deskew #(.col(COL), .psum_bw(BW), .depth(DEPTH), .ptr_bw(7)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference: one queue per column plus the visible registered state.
   logic [BW-1:0] mq [COL][$];
   logic [W-1:0]  m_out;
   logic          m_ov;
   logic          m_ovf;
   logic          m_udf;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd_row();
      logic [W-1:0] r;
      for (int k = 0; k < W/32; k++) r[32*k +: 32] = $urandom;
      return r;
   endfunction

   // Compare every DUT output with the reference after an edge.
   task automatic check_all();
      logic exp_valid;
      logic exp_full;
      exp_valid = 1'b1;
      exp_full  = 1'b0;
      for (int i = 0; i < COL; i++) begin
         if (mq[i].size() == 0)     exp_valid = 1'b0;
         if (mq[i].size() == DEPTH) exp_full  = 1'b1;
      end
      chk("out",         bif.out,         m_out);
      chk("o_out_valid", bif.o_out_valid, m_ov);
      chk("o_valid",     bif.o_valid,     exp_valid);
      chk("o_full",      bif.o_full,      exp_full);
      chk("o_ready",     bif.o_ready,     !exp_full);
      chk("o_ovf",       bif.o_ovf,       m_ovf);
      chk("o_udf",       bif.o_udf,       m_udf);
   endtask

   // One clock: drive inputs, take the edge, advance the reference, check.
   task automatic cyc(input logic r, input logic [COL-1:0] w, input logic [W-1:0] d, input logic rdv);
      logic           pre_valid;
      logic [COL-1:0] pre_full;
      reset   = r;
      bif.wr  = w;
      bif.in  = d;
      bif.rd  = rdv;
      pre_valid = 1'b1;
      for (int i = 0; i < COL; i++) begin
         pre_full[i] = (mq[i].size() == DEPTH);
         if (mq[i].size() == 0) pre_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (r) begin
         for (int i = 0; i < COL; i++) mq[i].delete();
         m_out = '0;
         m_ov  = 1'b0;
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else begin
         m_ov = rdv && pre_valid;
         if (rdv && !pre_valid) m_udf = 1'b1;
         if ((w & pre_full) != '0) m_ovf = 1'b1;
         if (m_ov) for (int i = 0; i < COL; i++) m_out[BW*i +: BW] = mq[i].pop_front();
         for (int i = 0; i < COL; i++)
            if (w[i] && !pre_full[i]) mq[i].push_back(d[BW*i +: BW]);
      end
      check_all();
   endtask

   initial begin
      logic [W-1:0] row;
      logic [W-1:0] rows [3];
      logic [W-1:0] first0;
      logic [W-1:0] a_row;
      logic [W-1:0] b_row;

      // Reset state
      cyc(1'b1, '0, '0, 1'b0);
      cyc(1'b1, '0, '0, 1'b0);
      chk("rst_ready", bif.o_ready, 1'b1);

      // Aligned rows
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < COL; i++) rows[k][BW*i +: BW] = 16'(16'h0100*k + i);
         cyc(1'b0, 8'hFF, rows[k], 1'b0);
      end
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, 8'h00, rnd_row(), 1'b1);
         chk("aligned_row", bif.out, rows[k]);
         chk("aligned_ov", bif.o_out_valid, 1'b1);
      end
      chk("aligned_empty", bif.o_valid, 1'b0);

      // Diagonal skew: column i written alone, one cycle apart
      for (int i = 0; i < COL; i++) begin
         row = rnd_row();
         row[BW*i +: BW] = 16'(i + 1);
         cyc(1'b0, 8'(1 << i), row, 1'b0);
         chk("skew_valid", bif.o_valid, (i == COL-1));
      end
      cyc(1'b0, 8'h00, rnd_row(), 1'b1);
      for (int i = 0; i < COL; i++) row[BW*i +: BW] = 16'(i + 1);
      chk("skew_row", bif.out, row);

      // Full and overflow on column 0
      first0 = '0;
      for (int n = 0; n < DEPTH; n++) begin
         row = rnd_row();
         if (n == 0) first0[BW-1:0] = row[BW-1:0];
         cyc(1'b0, 8'h01, row, 1'b0);
      end
      chk("full_flag", bif.o_full, 1'b1);
      cyc(1'b0, 8'h01, rnd_row(), 1'b0);
      chk("ovf_set", bif.o_ovf, 1'b1);
      row = rnd_row();
      first0[BW*1 +: BW] = row[BW*1 +: BW];
      cyc(1'b0, 8'h02, row, 1'b0);
      row = rnd_row();
      first0[W-1:2*BW] = row[W-1:2*BW];
      cyc(1'b0, 8'hFC, row, 1'b0);
      cyc(1'b0, 8'h00, rnd_row(), 1'b1);
      chk("full_first", bif.out, first0);
      cyc(1'b1, '0, '0, 1'b0);

      // Underflow: column 3 empty
      cyc(1'b0, 8'hF7, rnd_row(), 1'b0);
      row = bif.out;
      cyc(1'b0, 8'h00, rnd_row(), 1'b1);
      chk("udf_set", bif.o_udf, 1'b1);
      chk("udf_out_hold", bif.out, row);
      cyc(1'b0, 8'h08, rnd_row(), 1'b0);
      cyc(1'b0, 8'h00, rnd_row(), 1'b1);

      // Simultaneous read and write
      a_row = rnd_row();
      b_row = rnd_row();
      cyc(1'b0, 8'hFF, a_row, 1'b0);
      cyc(1'b0, 8'hFF, b_row, 1'b1);
      chk("rw_out_a", bif.out, a_row);
      chk("rw_valid", bif.o_valid, 1'b1);
      cyc(1'b0, 8'h00, rnd_row(), 1'b1);
      chk("rw_out_b", bif.out, b_row);
      chk("rw_empty", bif.o_valid, 1'b0);

      // Random traffic against the reference
      for (int n = 0; n < 400; n++) begin
         cyc(1'b0, 8'($urandom), rnd_row(), ($urandom_range(0, 2) == 0));
      end

      // Reset mid-operation with 10 rows queued
      cyc(1'b1, '0, '0, 1'b0);
      for (int n = 0; n < 10; n++) cyc(1'b0, 8'hFF, rnd_row(), 1'b0);
      cyc(1'b1, 8'h00, rnd_row(), 1'b1);
      chk("mid_rst_out", bif.out, '0);
      chk("mid_rst_valid", bif.o_valid, 1'b0);
      a_row = rnd_row();
      cyc(1'b0, 8'hFF, a_row, 1'b0);
      cyc(1'b0, 8'h00, rnd_row(), 1'b1);
      chk("mid_rst_new", bif.out, a_row);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
